// File: rtl/uart_tx_datapath_if.sv
// uart_tx_datapath_if
//   Bundles the host write port, the transmitter-FSM handshake and the
//   status flags of the UART transmit datapath.
//   Modports:
//     master - host/FSM side: drives wr_en, wr_data, ovf_clr, load, shift, busy
//              and observes tx_enable, txd, full, empty, count, overflow,
//              proto_err.
//     slave  - datapath side: the reverse directions.
//   Parameter AW is the FIFO pointer width; count is AW+1 bits wide.
interface uart_tx_datapath_if #(
    parameter int AW = 2
);
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          ovf_clr;
    logic          load;
    logic          shift;
    logic          busy;
    logic          tx_enable;
    logic          txd;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          proto_err;

    modport master (
        output wr_en, wr_data, ovf_clr, load, shift, busy,
        input  tx_enable, txd, full, empty, count, overflow, proto_err
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr, load, shift, busy,
        output tx_enable, txd, full, empty, count, overflow, proto_err
    );
endinterface

// File: rtl/uart_tx_datapath.sv
// uart_tx_datapath
//   UART transmit datapath sharing the bit clock with the transmitter FSM.
//   Host bytes are queued in a DEPTH-entry FIFO. On the FSM's load strobe the
//   oldest byte is framed as start(0) + 8 data bits LSB-first + stop(1); each
//   shift strobe moves the next bit onto txd. Dropped writes and protocol
//   misuse set sticky flags cleared by ovf_clr.
//   Ports:
//     fsm_clk - bit clock, rising edge
//     rst_n   - synchronous active-low reset
//     bus     - uart_tx_datapath_if.slave: host write, FSM handshake, status
//   Parameters:
//     DEPTH - FIFO depth in bytes (power of two, 2..16)
//     AW    - log2(DEPTH)
module uart_tx_datapath #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                    fsm_clk,
    input  logic                    rst_n,
    uart_tx_datapath_if.slave       bus
);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [9:0]    frame;
    logic          active;
    logic [3:0]    bit_cnt;
    logic          overflow_q;
    logic          proto_err_q;

    logic empty_w;
    logic full_w;
    logic pop;
    logic push;
    logic drop;
    logic proto_set;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == (AW+1)'(DEPTH));

    assign pop  = bus.load && !empty_w;
    // A full FIFO still accepts a write when a pop frees a slot this cycle.
    assign push = bus.wr_en && (!full_w || pop);
    assign drop = bus.wr_en && !push;

    // load takes priority over shift, so a stray shift alongside load only
    // counts as an error when the FSM does not claim to be busy.
    assign proto_set = (bus.load && empty_w)
                     || (bus.load && bus.shift && !bus.busy)
                     || (!bus.load && bus.shift && !active);

    // FIFO storage carries no reset: stale entries are never read because
    // the pointers and count are reset.
    always_ff @(posedge fsm_clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge fsm_clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            frame       <= '1;
            active      <= 1'b0;
            bit_cnt     <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);

            if (bus.load) begin
                if (!empty_w) begin
                    frame   <= {1'b1, mem[rd_ptr], 1'b0};
                    active  <= 1'b1;
                    bit_cnt <= '0;
                end else begin
                    // Keep the line idle rather than framing garbage.
                    frame <= '1;
                end
            end else if (bus.shift && active) begin
                frame   <= {1'b1, frame[9:1]};
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                end
            end

            // Set beats clear when both happen in the same cycle.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow_q <= 1'b0;
            end

            if (proto_set) begin
                proto_err_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                proto_err_q <= 1'b0;
            end
        end
    end

    // tx_enable covers the whole frame so the FSM never idles mid-frame.
    assign bus.tx_enable = !empty_w || active;
    assign bus.txd       = frame[0];
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_uart_tx_datapath.sv
// tb_uart_tx_datapath
//   Directed bench for uart_tx_datapath: framing, FIFO occupancy, back-to-back
//   frames, overflow, full-with-pop write, protocol errors and mid-frame reset.
//   Inputs change 1 ns after the rising edge; outputs are sampled at the same
//   point, reflecting the registers updated by that edge.
module tb_uart_tx_datapath;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic fsm_clk = 1'b0;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    uart_tx_datapath_if #(.AW(AW)) bus ();

    uart_tx_datapath #(.DEPTH(DEPTH), .AW(AW)) dut (
        .fsm_clk (fsm_clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    always #5 fsm_clk = ~fsm_clk;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge fsm_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;
        bus.load    = 1'b0;
        bus.shift   = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Expected line level for bit position i (0..9) of a frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    // Shift cycles k+1..k+10 after a load in cycle k; ends at start of k+11.
    task automatic shift_frame(input logic [7:0] b, input string tag);
        for (int i = 0; i < 10; i++) begin
            check({tag, "_txd"}, 32'(bus.txd), 32'(frame_bit(b, i)));
            check({tag, "_txen"}, 32'(bus.tx_enable), 32'd1);
            bus.shift = 1'b1;
            tick();
        end
        bus.shift = 1'b0;
    endtask

    task automatic load_cycle();
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        logic [7:0] q4 [4];
        q4[0] = 8'h00; q4[1] = 8'hFF; q4[2] = 8'h3C; q4[3] = 8'h81;

        idle_inputs();
        bus.busy = 1'b1;
        rst_n    = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_txd", 32'(bus.txd), 32'd1);
        check("rst_txen", 32'(bus.tx_enable), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_perr", 32'(bus.proto_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single frame 0xA5
        write_byte(8'hA5);
        check("a5_count1", 32'(bus.count), 32'd1);
        check("a5_txen", 32'(bus.tx_enable), 32'd1);
        load_cycle();
        check("a5_count0", 32'(bus.count), 32'd0);
        shift_frame(8'hA5, "a5");
        check("a5_idle_txd", 32'(bus.txd), 32'd1);
        check("a5_txen_fall", 32'(bus.tx_enable), 32'd0);
        check("a5_perr", 32'(bus.proto_err), 32'd0);

        // Fill FIFO
        for (int i = 0; i < 4; i++) write_byte(q4[i]);
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_count", 32'(bus.count), 32'd4);

        // Write to full FIFO without pop is dropped
        write_byte(8'h55);
        check("ovf_set", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd4);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_clr", 32'(bus.overflow), 32'd0);

        // Write to full FIFO with a pop in the same cycle is accepted
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h66;
        bus.load    = 1'b1;
        tick();
        idle_inputs();
        check("fullpop_count", 32'(bus.count), 32'd4);
        check("fullpop_ovf", 32'(bus.overflow), 32'd0);
        shift_frame(8'h00, "f00");
        load_cycle();
        shift_frame(8'hFF, "fFF");
        load_cycle();
        shift_frame(8'h3C, "f3C");
        load_cycle();
        shift_frame(8'h81, "f81");
        check("b2b_txen_gap", 32'(bus.tx_enable), 32'd1);
        load_cycle();
        shift_frame(8'h66, "f66");
        check("b2b_end_txen", 32'(bus.tx_enable), 32'd0);
        check("b2b_end_count", 32'(bus.count), 32'd0);
        check("b2b_end_perr", 32'(bus.proto_err), 32'd0);

        // Load while empty
        load_cycle();
        check("lde_perr", 32'(bus.proto_err), 32'd1);
        check("lde_txd", 32'(bus.txd), 32'd1);
        check("lde_count", 32'(bus.count), 32'd0);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("perr_clr", 32'(bus.proto_err), 32'd0);

        // Shift with no active frame, with ovf_clr in the same cycle: set wins
        bus.shift   = 1'b1;
        bus.ovf_clr = 1'b1;
        tick();
        idle_inputs();
        check("shn_perr", 32'(bus.proto_err), 32'd1);
        check("shn_txd", 32'(bus.txd), 32'd1);
        check("shn_count", 32'(bus.count), 32'd0);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;

        // load with shift while not busy is a protocol error
        write_byte(8'h0F);
        bus.busy  = 1'b0;
        bus.load  = 1'b1;
        bus.shift = 1'b1;
        tick();
        idle_inputs();
        bus.busy = 1'b1;
        check("ldsh_perr", 32'(bus.proto_err), 32'd1);
        shift_frame(8'h0F, "f0F");
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;

        // Reset mid-frame with two bytes queued
        write_byte(8'h12);
        write_byte(8'h34);
        write_byte(8'h56);
        load_cycle();
        check("mid_count", 32'(bus.count), 32'd2);
        for (int i = 0; i < 4; i++) begin
            check("mid_txd", 32'(bus.txd), 32'(frame_bit(8'h12, i)));
            bus.shift = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        bus.shift = 1'b0;
        rst_n = 1'b1;
        check("midrst_txd", 32'(bus.txd), 32'd1);
        check("midrst_count", 32'(bus.count), 32'd0);
        check("midrst_txen", 32'(bus.tx_enable), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_txd", 32'(bus.txd), 32'd1);
            check("post_txen", 32'(bus.tx_enable), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
